inv_key_schedule: RTL and testbench

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

---
 rtl/inv_key_schedule_if.sv | 26 ++
 rtl/inv_key_schedule.sv | 195 +++++++++++++++++++
 tb/tb_inv_key_schedule.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_key_schedule_if.sv
// Round-key stream bus: load request and cipher key in, round keys out.
interface inv_key_schedule_if;
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned ROUND_W = 4;

    logic                 start;
    logic [KEY_W-1:0]     key;
    logic                 rk_ready;
    logic                 rk_valid;
    logic [KEY_W-1:0]     rk;
    logic [ROUND_W-1:0]   rk_round;
    logic                 busy;
    logic                 done;

    // Requester side: issues start/key and consumes round keys
    modport master (
        output start, key, rk_ready,
        input  rk_valid, rk, rk_round, busy, done
    );

    // Key-schedule side
    modport slave (
        input  start, key, rk_ready,
        output rk_valid, rk, rk_round, busy, done
    );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: expands the cipher key forward to the
// round-10 key, then walks back emitting round keys 10 down to 0.
module inv_key_schedule (
    input  logic                clk,
    input  logic                rst,
    inv_key_schedule_if.slave   bus
);
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ROUND_W = 4;
    localparam logic [ROUND_W-1:0] LAST_ROUND = 4'd10;

    // Forward AES S-box, entry 0 in the most significant byte
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_EMIT   = 2'd2
    } state_e;

    state_e               state_q,    state_d;
    logic [KEY_W-1:0]     key_q,      key_d;
    logic [ROUND_W-1:0]   cnt_q,      cnt_d;
    logic [KEY_W-1:0]     rk_q,       rk_d;
    logic [ROUND_W-1:0]   rk_round_q, rk_round_d;
    logic                 rk_valid_q, rk_valid_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;

    logic [WORD_W-1:0]    g_in_c;
    logic [WORD_W-1:0]    rot_c;
    logic [WORD_W-1:0]    sub_c;
    logic [ROUND_W-1:0]   rcon_idx_c;
    logic [7:0]           rcon_c;
    logic [WORD_W-1:0]    g_out_c;
    logic [KEY_W-1:0]     fwd_key_c;
    logic [KEY_W-1:0]     rev_key_c;

    // Round constant for rounds 1..10
    function automatic logic [7:0] rcon_of(input logic [ROUND_W-1:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Shared g() path: forward step feeds w[4r-1] from the key register,
    // reverse step feeds w[4r-1] = d ^ c recovered from the current round key
    always_comb begin
        if (state_q == ST_EMIT) begin
            g_in_c     = rk_q[63:32] ^ rk_q[31:0];
            rcon_idx_c = rk_round_q;
        end else begin
            g_in_c     = key_q[31:0];
            rcon_idx_c = ROUND_W'(cnt_q + 4'd1);
        end
        rot_c   = {g_in_c[23:0], g_in_c[31:24]};
        sub_c   = {SBOX[rot_c[31:24]], SBOX[rot_c[23:16]],
                   SBOX[rot_c[15:8]],  SBOX[rot_c[7:0]]};
        rcon_c  = rcon_of(rcon_idx_c);
        g_out_c = sub_c ^ {rcon_c, 24'h0};
    end

    // One forward expansion step on the key register
    always_comb begin
        logic [WORD_W-1:0] n0, n1, n2, n3;
        n0 = key_q[127:96] ^ g_out_c;
        n1 = key_q[95:64]  ^ n0;
        n2 = key_q[63:32]  ^ n1;
        n3 = key_q[31:0]   ^ n2;
        fwd_key_c = {n0, n1, n2, n3};
    end

    // One reverse step from round r to round r-1 on the output key
    always_comb begin
        logic [WORD_W-1:0] a, b, c, d;
        a = rk_q[127:96];
        b = rk_q[95:64];
        c = rk_q[63:32];
        d = rk_q[31:0];
        rev_key_c = {a ^ g_out_c, b ^ a, c ^ b, d ^ c};
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        cnt_d      = cnt_q;
        rk_d       = rk_q;
        rk_round_d = rk_round_q;
        rk_valid_d = rk_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    key_d   = bus.key;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (cnt_q == LAST_ROUND) begin
                    // Key register now holds the round-10 key
                    rk_d       = key_q;
                    rk_round_d = LAST_ROUND;
                    rk_valid_d = 1'b1;
                    state_d    = ST_EMIT;
                end else begin
                    key_d = fwd_key_c;
                    cnt_d = ROUND_W'(cnt_q + 4'd1);
                end
            end
            ST_EMIT: begin
                if (rk_valid_q && bus.rk_ready) begin
                    if (rk_round_q == '0) begin
                        rk_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        rk_d       = rev_key_c;
                        rk_round_d = ROUND_W'(rk_round_q - 4'd1);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rk_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            cnt_q      <= '0;
            rk_q       <= '0;
            rk_round_q <= '0;
            rk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            cnt_q      <= cnt_d;
            rk_q       <= rk_d;
            rk_round_q <= rk_round_d;
            rk_valid_q <= rk_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rk_valid = rk_valid_q;
    assign bus.rk       = rk_q;
    assign bus.rk_round = rk_round_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for the AES-128 inverse key schedule.
module tb_inv_key_schedule;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;

    localparam logic [0:255][7:0] SB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:10][7:0] RC = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
                                      8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   inject   = 1'b0;
    logic [127:0] ref_rk [11];

    inv_key_schedule_if bus ();

    inv_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // FIPS-197 key expansion, 44 words, stored per round
    task automatic build_ref(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]} ^ {RC[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_valid"}, 128'(bus.rk_valid), 128'(0));
        chk({tag, "_busy"},  128'(bus.busy),     128'(0));
        chk({tag, "_done"},  128'(bus.done),     128'(0));
        chk({tag, "_rk"},    bus.rk,             128'(0));
        chk({tag, "_round"}, 128'(bus.rk_round), 128'(0));
    endtask

    // Called at the negedge following the accepting edge
    task automatic wait_valid(input logic [127:0] k);
        int c;
        c = 0;
        chk("busy_after_start", 128'(bus.busy), 128'(1));
        while (!bus.rk_valid && c < 40) begin
            if (inject && c == 5) begin
                bus.start = 1'b1;
                bus.key   = ~k;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        bus.start = 1'b0;
        chk("first_valid_latency", 128'(c), 128'(11));
    endtask

    task automatic start_run(input logic [127:0] k);
        bus.start = 1'b1;
        bus.key   = k;
        @(negedge clk);
        bus.start = 1'b0;
        bus.key   = ~k;
        wait_valid(k);
    endtask

    // Drain all 11 keys; optionally request the next run during the last handshake
    task automatic consume(input logic [127:0] k, input bit rnd, input bit chain,
                           input logic [127:0] next_k);
        int r, guard;
        bit rdy, stalled;
        logic [127:0] held_rk;
        logic [3:0]   held_round;
        build_ref(k);
        r = 10; guard = 0; stalled = 1'b0;
        held_rk = '0; held_round = '0;
        while (r >= 0 && guard < 400) begin
            chk("valid_in_emit", 128'(bus.rk_valid), 128'(1));
            if (stalled) begin
                chk("stall_rk",    bus.rk,             held_rk);
                chk("stall_round", 128'(bus.rk_round), 128'(held_round));
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.start = 1'b0;
            if (inject && r == 5) begin
                bus.start = 1'b1;
                bus.key   = ~k;
            end
            if (bus.rk_valid && rdy) begin
                chk("rk",       bus.rk,             ref_rk[r]);
                chk("rk_round", 128'(bus.rk_round), 128'(r));
                if (k == FIPS_KEY && r == 10) chk("fips_r10", bus.rk, FIPS_R10);
                if (k == FIPS_KEY && r == 1)  chk("fips_r1",  bus.rk, FIPS_R1);
                if (k == FIPS_KEY && r == 0)  chk("fips_r0",  bus.rk, FIPS_KEY);
                if (chain && r == 0) begin
                    bus.start = 1'b1;
                    bus.key   = next_k;
                end
                r--;
                stalled = 1'b0;
            end else begin
                stalled    = 1'b1;
                held_rk    = bus.rk;
                held_round = bus.rk_round;
            end
            bus.rk_ready = rdy;
            @(negedge clk);
            guard++;
        end
        bus.rk_ready = 1'b0;
        chk("handshakes_left", 128'(r + 1), 128'(0));
        chk("done_pulse",      128'(bus.done),     128'(1));
        chk("valid_drop",      128'(bus.rk_valid), 128'(0));
        chk("busy_drop",       128'(bus.busy),     128'(0));
    endtask

    task automatic run(input logic [127:0] k, input bit rnd);
        start_run(k);
        consume(k, rnd, 1'b0, '0);
        @(negedge clk);
        chk("done_one_cycle", 128'(bus.done), 128'(0));
        chk("idle_holds_rk",  bus.rk,          k);
    endtask

    initial begin
        logic [127:0] k;
        int g;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.key      = '0;
        bus.rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Known-answer run, then same key under random back-pressure
        run(FIPS_KEY, 1'b0);
        run(FIPS_KEY, 1'b1);

        // Boundary and random keys
        run(128'h0, 1'b0);
        run({128{1'b1}}, 1'b1);
        for (int i = 0; i < 3; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            run(k, 1'($urandom_range(0, 1)));
        end

        // start pulses with a different key during EXPAND and EMIT
        inject = 1'b1;
        run(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
        inject = 1'b0;

        // Reset during EXPAND
        bus.start = 1'b1;
        bus.key   = FIPS_KEY;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_zero("rst_expand");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_expand_nodone", 128'(bus.done), 128'(0));
        run(FIPS_KEY, 1'b0);

        // Reset during EMIT at round 4
        start_run(FIPS_KEY);
        bus.rk_ready = 1'b1;
        g = 0;
        while (bus.rk_round != 4'd4 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("reach_round4", 128'(bus.rk_round), 128'(4));
        rst = 1'b1;
        #1;
        check_idle_zero("rst_emit");
        @(negedge clk);
        rst = 1'b0;
        bus.rk_ready = 1'b0;
        @(negedge clk);
        chk("rst_emit_nodone", 128'(bus.done), 128'(0));
        chk("rst_emit_idle",   128'(bus.busy), 128'(0));
        run(128'hffeeddccbbaa99887766554433221100, 1'b1);

        // start held across done: next run follows immediately
        start_run(FIPS_KEY);
        consume(FIPS_KEY, 1'b0, 1'b1, 128'h0f1571c947d9e8590cb7add6af7f6798);
        @(negedge clk);
        bus.start = 1'b0;
        bus.key   = '0;
        wait_valid(128'h0f1571c947d9e8590cb7add6af7f6798);
        consume(128'h0f1571c947d9e8590cb7add6af7f6798, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("chain_done_one_cycle", 128'(bus.done), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
